// File: rtl/teclado_pkg.sv
// Shared constants and helpers for the keypad front end and its downstream encoder.
package teclado_pkg;

  localparam int unsigned N_KEYS_DEFAULT = 10;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  // Takes a zero-extended vector so callers of any width up to 32 can share it.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/teclado_sync.sv
// Two-flop synchroniser for the asynchronous raw key lines.
module teclado_sync #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/teclado_debounce.sv
// Debounces the keypad lines, rejects multi-key presses and emits a held one-hot key vector
// plus a single-cycle strobe per accepted press.
module teclado_debounce
  import teclado_pkg::*;
#(
  parameter int unsigned N_KEYS          = N_KEYS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_out,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_key
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_KEYS-1:0] sync_q;
  logic              sync_onehot;
  logic              sync_zero;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_KEYS-1:0] cand_q, cand_d;
  logic [N_KEYS-1:0] key_out_q, key_out_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;

  teclado_sync #(
    .WIDTH (N_KEYS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (sync_q)
  );

  assign sync_onehot = is_onehot(32'(sync_q));
  assign sync_zero   = (sync_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_out_d   = key_out_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = !sync_zero && !sync_onehot;

    unique case (state_q)
      IDLE: begin
        if (sync_onehot) begin
          cand_d  = sync_q;
          cnt_d   = CNT_ONE;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync_q != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          state_d     = PRESSED;
          key_out_d   = cand_q;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        // Roll-over: extra or different keys are ignored until every line is released.
        if (sync_zero) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!sync_zero) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          state_d    = IDLE;
          key_out_d  = '0;
          key_held_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_teclado_debounce.sv
// Directed bench for teclado_debounce at N_KEYS=10, DEBOUNCE_CYCLES=4.
module tb_teclado_debounce;
  import teclado_pkg::*;

  logic       clk;
  logic       rst;
  logic [9:0] key_raw;
  logic [9:0] key_out;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  int viol_cnt  = 0;
  logic prev_valid = 1'b0;
  int v0;

  teclado_debounce #(
    .N_KEYS          (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe count and output invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (key_valid === 1'b1) valid_cnt++;
    if (key_valid === 1'b1 && prev_valid === 1'b1) viol_cnt++;
    if (key_out !== 10'd0 && !is_onehot(32'(key_out))) viol_cnt++;
    prev_valid = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    key_raw = 10'd0;
    tick(2);
    check("rst_key_out", 32'(key_out), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    check("rst_multi_key", 32'(multi_key), 32'h0);
    rst = 1'b0;

    // Clean press and release of key 3.
    v0 = valid_cnt;
    key_raw = 10'b0000001000;
    tick(5);
    check("t1_no_valid_edge4", 32'(key_valid), 32'h0);
    check("t1_no_out_edge4", 32'(key_out), 32'h0);
    tick(1);
    check("t1_valid_edge5", 32'(key_valid), 32'h1);
    check("t1_out_edge5", 32'(key_out), 32'h008);
    check("t1_held_edge5", 32'(key_held), 32'h1);
    tick(1);
    check("t1_valid_drops", 32'(key_valid), 32'h0);
    check("t1_out_held", 32'(key_out), 32'h008);
    key_raw = 10'd0;
    tick(5);
    check("t1_rel_out_edge4", 32'(key_out), 32'h008);
    check("t1_rel_held_edge4", 32'(key_held), 32'h1);
    tick(1);
    check("t1_rel_out_edge5", 32'(key_out), 32'h0);
    check("t1_rel_held_edge5", 32'(key_held), 32'h0);
    check("t1_valid_count", 32'(valid_cnt - v0), 32'd1);

    // Bounce: 2-cycle toggling never survives four matching samples.
    v0 = valid_cnt;
    for (int i = 0; i < 10; i++) begin
      key_raw = (i % 2 == 0) ? 10'b0000000001 : 10'b0000000000;
      tick(2);
    end
    check("t2_no_valid_bounce", 32'(valid_cnt - v0), 32'd0);
    check("t2_no_out_bounce", 32'(key_out), 32'h0);
    key_raw = 10'b0000000001;
    tick(10);
    check("t2_valid_once", 32'(valid_cnt - v0), 32'd1);
    check("t2_out", 32'(key_out), 32'h001);
    key_raw = 10'd0;
    tick(8);
    check("t2_released", 32'(key_out), 32'h0);

    // Multi-key press is flagged and never accepted.
    v0 = valid_cnt;
    key_raw = 10'b0000100100;
    tick(2);
    check("t3_multi_edge1", 32'(multi_key), 32'h0);
    tick(1);
    check("t3_multi_edge2", 32'(multi_key), 32'h1);
    tick(10);
    check("t3_multi_held", 32'(multi_key), 32'h1);
    check("t3_no_out", 32'(key_out), 32'h0);
    check("t3_no_held", 32'(key_held), 32'h0);
    check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
    key_raw = 10'd0;
    tick(3);
    check("t3_multi_clears", 32'(multi_key), 32'h0);

    // Roll-over: key 9 accepted, key 0 added, key 9 lifted, then all released.
    v0 = valid_cnt;
    key_raw = 10'b1000000000;
    tick(6);
    check("t4_valid", 32'(key_valid), 32'h1);
    check("t4_out", 32'(key_out), 32'h200);
    key_raw = 10'b1000000001;
    tick(8);
    check("t4_rollover_out", 32'(key_out), 32'h200);
    check("t4_rollover_multi", 32'(multi_key), 32'h1);
    key_raw = 10'b0000000001;
    tick(8);
    check("t4_partial_out", 32'(key_out), 32'h200);
    check("t4_partial_held", 32'(key_held), 32'h1);
    key_raw = 10'd0;
    tick(5);
    check("t4_rel_edge4", 32'(key_out), 32'h200);
    tick(1);
    check("t4_rel_edge5", 32'(key_out), 32'h0);
    check("t4_valid_once", 32'(valid_cnt - v0), 32'd1);

    // Release glitch shorter than the debounce window returns to PRESSED.
    v0 = valid_cnt;
    key_raw = 10'b0000100000;
    tick(6);
    check("t5_valid", 32'(key_valid), 32'h1);
    key_raw = 10'd0;
    tick(2);
    key_raw = 10'b0000100000;
    tick(4);
    check("t5_glitch_out", 32'(key_out), 32'h020);
    check("t5_glitch_held", 32'(key_held), 32'h1);
    key_raw = 10'd0;
    tick(5);
    check("t5_rel_edge4", 32'(key_out), 32'h020);
    tick(1);
    check("t5_rel_edge5", 32'(key_out), 32'h0);
    check("t5_valid_once", 32'(valid_cnt - v0), 32'd1);

    // Reset at cnt=2 in DEBOUNCE, then a full-latency re-press.
    key_raw = 10'b0000010000;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("t6_rst_out", 32'(key_out), 32'h0);
    check("t6_rst_valid", 32'(key_valid), 32'h0);
    check("t6_rst_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    tick(5);
    check("t6_repress_edge4", 32'(key_valid), 32'h0);
    tick(1);
    check("t6_repress_edge5", 32'(key_valid), 32'h1);
    check("t6_repress_out", 32'(key_out), 32'h010);

    // Reset while PRESSED clears the held key immediately.
    rst = 1'b1;
    tick(1);
    check("t6_rst_pressed_out", 32'(key_out), 32'h0);
    check("t6_rst_pressed_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    key_raw = 10'd0;
    tick(8);

    check("invariants", 32'(viol_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
